audio_capture_ctrl: RTL and testbench
=====================================

Name: audio_capture_ctrl

Overview:
- Sequences one capture of the filtered microphone stream (16-bit signed samples with a valid strobe) into a sample buffer.
- After a start command it discards a warm-up run of samples, arms a level trigger, then writes a fixed-length window to buffer write ports.
- Sits between the microphone/FIR output and the capture RAM; software or top-level logic starts it and consumes done.

Parameters:
- WARMUP_SAMPLES, 4096: valid samples discarded after start (mic settling); must be >= 1.
- CAPTURE_LEN, 1024: samples written per capture; must be >= 1 and <= 2**ADDR_W.
- ADDR_W, 10: buffer address width.

Ports:
- clk_in  input  1  system clock (98.304 MHz domain)
- rst_in_n  input  1  asynchronous, active-low reset
- start_in  input  1  single-cycle capture request
- abort_in  input  1  cancel current capture
- threshold_in  input  16  unsigned trigger level, compared against |sample|
- audio_data_in  input  16  signed sample
- audio_valid_in  input  1  sample strobe (at most one per cycle, typically ~1 per 3072 cycles)
- wr_en_out  output  1  buffer write enable
- wr_addr_out  output  ADDR_W  buffer write address
- wr_data_out  output  16  buffer write data
- busy_out  output  1  high in any state but IDLE
- done_out  output  1  one-cycle pulse on capture completion
- state_out  output  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in_n is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; sample counter 0.
- States and transitions (state_out encoding):
  - IDLE=0: start_in -> WARMUP, counter cleared.
  - WARMUP=1: counter increments on each audio_valid_in. The valid that makes the count equal WARMUP_SAMPLES -> ARMED; that sample is discarded.
  - ARMED=2: on audio_valid_in with |audio_data_in| >= threshold_in -> CAPTURE. This trigger sample is written at address 0.
  - CAPTURE=3: each audio_valid_in is written at the next address. The write at address CAPTURE_LEN-1 -> DONE.
  - DONE=4: unconditionally -> IDLE next cycle.
- Magnitude:
  - |x| for x = -32768 saturates to 32767.
  - threshold_in = 0 triggers on the first armed sample.
  - threshold_in > 32767 never triggers; the block stays ARMED until abort.
- Write timing:
  - Registered output stage: wr_en_out, wr_addr_out and wr_data_out are asserted the cycle after the accepted audio_valid_in.
  - wr_data_out equals that sample unmodified.
  - wr_en_out is low in all other cycles; wr_addr_out and wr_data_out hold their last value when wr_en_out is low.
- done_out:
  - Pulses in the cycle state_out = DONE, i.e. the cycle after the final wr_en_out.
  - busy_out is still high in that cycle and falls the following cycle.
- start_in when busy: ignored (no restart, no error).
- abort_in:
  - In any non-IDLE state -> IDLE next cycle; no done_out, and no write issued for a sample arriving in the same cycle.
  - Priority over every other event in that cycle.
  - A write already registered from the previous cycle still completes.
- start_in and abort_in together in IDLE: abort wins; stay IDLE.
- Reset mid-operation: immediate return to reset values; no partial done.
- Samples are never stalled; a sample arriving while IDLE or DONE is dropped.

Optional Feature:
- Macro: AUDIO_CAPTURE_PEAK_EN.
- Defined:
  - Adds output peak_out [15:0], the maximum |sample| (saturating, as above) over the samples written in the current capture.
  - Cleared to 0 on leaving IDLE.
  - Updated in the same cycle as the corresponding wr_en_out.
  - Holds its value after DONE until the next start.
  - Reset value 0.
- Undefined: no peak_out port and no peak logic.

Test Plan:
All scenarios use WARMUP_SAMPLES=4, CAPTURE_LEN=8, ADDR_W=3 unless stated.
- Basic capture: start, threshold=100, samples 1..4 (warm-up), then 50, 200, 201..207 -> 50 not written; 200 written at addr 0, 201..207 at 1..7; done_out one pulse one cycle after the addr-7 write; busy_out low the next cycle; exactly 8 wr_en_out pulses.
- Negative trigger and saturation: threshold=32767, armed sample -32768 -> triggers; wr_data_out=0x8000 at addr 0; with AUDIO_CAPTURE_PEAK_EN, peak_out=32767.
- Abort in CAPTURE after 3 writes -> state 0 next cycle; no done_out; the next start restarts warm-up from count 0 and first capture writes again begin at addr 0.
- start_in pulses during WARMUP and CAPTURE -> no effect on counter, address or state sequence; result identical to the basic capture.
- Async reset asserted mid-WARMUP, between clock edges -> all outputs 0 and state_out=0 immediately, without waiting for a clock edge; simultaneous start_in+abort_in in IDLE -> stays IDLE.
- threshold=0, back-to-back audio_valid_in every cycle -> capture begins on the 5th sample; 8 consecutive-cycle writes, addr 0..7, no drops.

Source files
------------

// File: rtl/audio_capture_ctrl.sv
// -----------------------------------------------------------------------------
// audio_capture_ctrl
//
// Purpose:
//   Sequences one capture of the filtered microphone stream into a sample
//   buffer. After start_in it drops WARMUP_SAMPLES valid samples while the
//   microphone settles. It then arms a level trigger on |sample| >=
//   threshold_in. Finally it writes CAPTURE_LEN samples, starting with the
//   trigger sample, to the buffer write port and pulses done_out.
//
// Optional feature (macro AUDIO_CAPTURE_PEAK_EN):
//   When the macro is defined, the block adds peak_out. This is the running
//   maximum |sample| over the samples written in the current capture.
//
// Ports:
//   clk_in          system clock
//   rst_in_n        asynchronous active-low reset
//   start_in        single-cycle capture request (ignored while busy)
//   abort_in        cancel; beats every other event in the same cycle
//   threshold_in    unsigned trigger level compared against |sample|
//   audio_data_in   signed 16-bit sample
//   audio_valid_in  sample strobe
//   wr_en_out       buffer write enable (registered)
//   wr_addr_out     buffer write address (holds while wr_en_out is low)
//   wr_data_out     buffer write data    (holds while wr_en_out is low)
//   busy_out        high in every state except IDLE
//   done_out        one-cycle pulse while state_out is DONE
//   state_out       0 IDLE, 1 WARMUP, 2 ARMED, 3 CAPTURE, 4 DONE
//   peak_out        (AUDIO_CAPTURE_PEAK_EN only) peak |sample| of the capture
// -----------------------------------------------------------------------------
module audio_capture_ctrl #(
  parameter int WARMUP_SAMPLES = 4096,
  parameter int CAPTURE_LEN    = 1024,
  parameter int ADDR_W         = 10
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [15:0]       threshold_in,
  input  logic [15:0]       audio_data_in,
  input  logic              audio_valid_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [15:0]       wr_data_out,
  output logic              busy_out,
  output logic              done_out,
`ifdef AUDIO_CAPTURE_PEAK_EN
  output logic [2:0]        state_out,
  output logic [15:0]       peak_out
`else
  output logic [2:0]        state_out
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int                CNT_W       = $clog2(WARMUP_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  WARMUP_LAST = CNT_W'(WARMUP_SAMPLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(CAPTURE_LEN - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic              busy_q;
  logic              done_q;

  logic [15:0]       mag_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              trigger_d;
  logic              final_wr_d;
  logic              first_wr_d;
  logic              next_wr_d;

  // |x| saturates so that -32768 maps to 32767. As a result, a threshold
  // above 32767 can never fire.
  always_comb begin
    mag_d = audio_data_in;
    if (audio_data_in[15]) begin
      mag_d = (audio_data_in == 16'h8000) ? 16'h7FFF : (~audio_data_in + 16'd1);
    end
  end

  assign cnt_d     = cnt_q + 1'b1;
  assign trigger_d = (mag_d >= threshold_in);

  // The last write is on the output this cycle, so CAPTURE leaves for DONE
  // at the next edge. This makes done_out follow the final wr_en_out by one
  // cycle. Any sample that arrives in this cycle is dropped.
  assign final_wr_d = wr_en_q && (wr_addr_q == ADDR_LAST);

  assign first_wr_d = !abort_in && (state_q == ST_ARMED) && audio_valid_in && trigger_d;
  assign next_wr_d  = !abort_in && (state_q == ST_CAPTURE) && !final_wr_d && audio_valid_in;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort_in) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_in) begin
              state_q <= ST_WARMUP;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_WARMUP: begin
            if (audio_valid_in) begin
              cnt_q <= cnt_d;
              if (cnt_d == WARMUP_LAST) begin
                state_q <= ST_ARMED;
              end
            end
          end
          ST_ARMED: begin
            if (first_wr_d) begin
              state_q   <= ST_CAPTURE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= audio_data_in;
            end
          end
          ST_CAPTURE: begin
            if (final_wr_d) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (next_wr_d) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_addr_q + 1'b1;
              wr_data_q <= audio_data_in;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef AUDIO_CAPTURE_PEAK_EN
  logic [15:0] peak_q;

  // The peak register is written on the same edge as the buffer write, so
  // it moves in step with wr_en_out. It is cleared only when a start is
  // accepted. This keeps the result readable after DONE.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      peak_q <= '0;
    end else if (!abort_in && (state_q == ST_IDLE) && start_in) begin
      peak_q <= '0;
    end else if (first_wr_d) begin
      peak_q <= mag_d;
    end else if (next_wr_d && (mag_d > peak_q)) begin
      peak_q <= mag_d;
    end
  end

  assign peak_out = peak_q;
`else
  // Without the peak option there is no peak register and no peak port.
`endif

  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_audio_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_audio_capture_ctrl
//
// Directed bench for audio_capture_ctrl with WARMUP_SAMPLES=4, CAPTURE_LEN=8
// and ADDR_W=3. Each stimulus task pushes the buffer write it expects into a
// queue. The expected write includes its address, its data, the cycle it
// must appear in, and the running peak. A free-running monitor pops the
// queue and compares each time the DUT shows wr_en_out. The monitor also
// checks the timing of done and busy.
// -----------------------------------------------------------------------------
module tb_audio_capture_ctrl;

  localparam int WARM = 4;
  localparam int LEN  = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          valid = 1'b0;
  logic [15:0]   thr = 16'd0;
  logic [15:0]   din = 16'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;
  logic [2:0]    state;
`ifdef AUDIO_CAPTURE_PEAK_EN
  logic [15:0]   peak;
`endif

  audio_capture_ctrl #(
    .WARMUP_SAMPLES(WARM),
    .CAPTURE_LEN   (LEN),
    .ADDR_W        (AW)
  ) dut (
    .clk_in        (clk),
    .rst_in_n      (rst_n),
    .start_in      (start),
    .abort_in      (abort),
    .threshold_in  (thr),
    .audio_data_in (din),
    .audio_valid_in(valid),
    .wr_en_out     (wr_en),
    .wr_addr_out   (wr_addr),
    .wr_data_out   (wr_data),
    .busy_out      (busy),
    .done_out      (done),
`ifdef AUDIO_CAPTURE_PEAK_EN
    .state_out     (state),
    .peak_out      (peak)
`else
    .state_out     (state)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
    logic [15:0]   peak;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] exp_peak = 16'd0;
  bit          prev_final = 1'b0;
  bit          prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mag16(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    if (x[15]) return -x;
    return x;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_final = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_done) chk("busy_fall_after_done", busy, 0);
      if (wr_en) begin
        wr_cnt++;
        $display("write addr=%0d data=%04h cycle=%0d", wr_addr, wr_data, cyc);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %04h, expected no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_data", wr_data, mon_e.data);
          chk("wr_cycle", cyc, mon_e.cyc);
`ifdef AUDIO_CAPTURE_PEAK_EN
          chk("peak", peak, mon_e.peak);
`endif
        end
      end
      if (done) begin
        done_cnt++;
        $display("done pulse cycle=%0d", cyc);
        chk("done_after_final_write", prev_final, 1);
        chk("done_state", state, 4);
        chk("done_busy", busy, 1);
      end
      prev_final = wr_en && (wr_addr == AW'(LEN - 1));
      prev_done  = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drive one sample for one cycle. Consecutive calls with nothing in
  // between give back-to-back strobes.
  task automatic samp(input logic [15:0] d, input bit w, input int a);
    valid = 1'b1;
    din   = d;
    if (w) begin
      wr_t e;
      if (a == 0) exp_peak = mag16(d);
      else if (mag16(d) > exp_peak) exp_peak = mag16(d);
      e.addr = AW'(a);
      e.data = d;
      e.cyc  = cyc + 1;
      e.peak = exp_peak;
      exp_q.push_back(e);
    end
    step();
    valid = 1'b0;
  endtask

  task automatic begin_scn();
    wr_cnt   = 0;
    done_cnt = 0;
    exp_peak = 16'd0;
  endtask

  task automatic end_scn(input string name, input int nwr, input int ndone);
    int t = 0;
    while ((exp_q.size() != 0 || state != 3'd0) && t < 50) begin
      step();
      t++;
    end
    idle(2);
    chk({name, "_timeout"}, (t < 50), 1);
    chk({name, "_wr_count"}, wr_cnt, nwr);
    chk({name, "_done_count"}, done_cnt, ndone);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy_idle"}, busy, 0);
    exp_q.delete();
  endtask

  task automatic basic(input string name, input bit extra_starts);
    begin_scn();
    thr = 16'd100;
    pulse_start();
    chk({name, "_warmup_entry"}, state, 1);
    for (int i = 1; i <= WARM; i++) begin
      samp(16'(i), 0, 0);
      chk({name, "_warm_state"}, state, (i == WARM) ? 2 : 1);
      idle(1);
      if (extra_starts && i == 2) pulse_start();
    end
    samp(16'd50, 0, 0);
    idle(1);
    chk({name, "_below_thr"}, state, 2);
    samp(16'd200, 1, 0);
    chk({name, "_capture_entry"}, state, 3);
    idle(1);
    for (int a = 1; a < LEN; a++) begin
      samp(16'(200 + a), 1, a);
      idle(2);
      if (extra_starts && a == 3) pulse_start();
    end
    end_scn(name, LEN, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
`ifdef AUDIO_CAPTURE_PEAK_EN
    chk("rst_peak", peak, 0);
`endif
    rst_n = 1'b1;
    idle(2);

    // Basic capture
    basic("basic", 1'b0);

    // Start pulses while busy change nothing
    basic("restart_ignored", 1'b1);

    // Negative trigger with saturation
    begin_scn();
    thr = 16'd32767;
    pulse_start();
    for (int i = 0; i < WARM; i++) samp(16'd5, 0, 0);
    samp(16'h8000, 1, 0);
    for (int a = 1; a < LEN; a++) samp(16'(a), 1, a);
    end_scn("saturate", LEN, 1);

    // A threshold above 32767 never fires; abort leaves ARMED
    begin_scn();
    thr = 16'h8000;
    pulse_start();
    for (int i = 0; i < WARM; i++) samp(16'd5, 0, 0);
    samp(16'h8000, 0, 0);
    samp(16'h7FFF, 0, 0);
    idle(1);
    chk("no_trigger_armed", state, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("no_trigger_abort", state, 0);
    end_scn("no_trigger", 0, 0);

    // Abort in CAPTURE after three writes, with a sample in the same cycle
    begin_scn();
    thr = 16'd100;
    pulse_start();
    for (int i = 0; i < WARM; i++) samp(16'd1000, 0, 0);
    samp(16'd300, 1, 0);
    samp(16'd301, 1, 1);
    samp(16'd302, 1, 2);
    abort = 1'b1;
    valid = 1'b1;
    din   = 16'd303;
    step();
    abort = 1'b0;
    valid = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    end_scn("abort", 3, 0);

    // The next capture warms up from zero and writes from address 0
    begin_scn();
    pulse_start();
    for (int i = 0; i < WARM; i++) samp(16'd1000, 0, 0);
    for (int a = 0; a < LEN; a++) samp(16'(400 + a), 1, a);
    end_scn("after_abort", LEN, 1);

    // Asynchronous reset between clock edges in WARMUP
    begin_scn();
    pulse_start();
    samp(16'd1, 0, 0);
    samp(16'd2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_wr_addr", wr_addr, 0);
    chk("async_rst_wr_data", wr_data, 0);
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    end_scn("async_rst", 0, 0);

    // start and abort together in IDLE
    begin_scn();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_state", state, 0);
    chk("start_abort_busy", busy, 0);
    samp(16'd1000, 0, 0);
    idle(2);
    chk("start_abort_still_idle", state, 0);
    end_scn("start_abort", 0, 0);

    // threshold 0, one sample every cycle. The 5th sample triggers. The two
    // trailing samples arrive after the last write and are dropped.
    begin_scn();
    thr = 16'd0;
    pulse_start();
    for (int i = 0; i < 14; i++) samp(16'(10 + i), (i >= WARM) && (i < WARM + LEN), i - WARM);
    end_scn("thr0_b2b", LEN, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
